// File: rtl/apbspi_sched_pkg.sv
// Shared types and default sizing for the APB-SPI transfer scheduler.
package apbspi_sched_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_LEN_WIDTH = 8;
  localparam int DEF_DLY_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } sched_state_e;

endpackage

// File: rtl/apbspi_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins.
module apbspi_rr_arbiter
  import apbspi_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   rot_gnt;
  logic [2*N_REQ-1:0] unrot;
  logic               found;

  // Rotate so the search always starts at bit 0, then rotate the winner back.
  assign rot = N_REQ'({req, req} >> ptr);

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    rot_gnt = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i] && !found) begin
        rot_gnt[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign unrot = {{N_REQ{1'b0}}, rot_gnt} << ptr;
  assign grant = unrot[N_REQ-1:0] | unrot[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/apbspi_xfer_sched.sv
// Schedules multi-word SPI bursts from several requesters onto one SPI engine,
// sequencing chip-select setup, word transfers, hold and inter-burst gap.
module apbspi_xfer_sched
  import apbspi_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int DLY_WIDTH = DEF_DLY_WIDTH
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_WIDTH-1:0] req_len,
  input  logic [DLY_WIDTH-1:0]       cs_setup,
  input  logic [DLY_WIDTH-1:0]       cs_hold,
  input  logic [DLY_WIDTH-1:0]       cs_gap,
  input  logic                       spi_enable,
  input  logic                       spi_busy,
  input  logic                       spi_trx_done,
  output logic                       spi_start,
  output logic [N_REQ-1:0]           cs_n,
  output logic [N_REQ-1:0]           grant,
  output logic                       word_done,
  output logic [N_REQ-1:0]           burst_done,
  output logic                       burst_abort
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e         state, state_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [DLY_WIDTH-1:0] cnt, cnt_nxt;
  logic [LEN_WIDTH-1:0] remaining, remaining_nxt;
  logic [N_REQ-1:0]     eligible, win;
  logic [PTR_W-1:0]     win_idx;
  logic [LEN_WIDTH-1:0] win_len;
  logic                 start_grant, abort;

  logic                 spi_start_nxt, word_done_nxt, burst_abort_nxt;
  logic [N_REQ-1:0]     cs_n_nxt, grant_nxt, burst_done_nxt;

  // A delay of 0 still occupies its state for one cycle.
  function automatic logic dly_done(input logic [DLY_WIDTH-1:0] c,
                                    input logic [DLY_WIDTH-1:0] d);
    return (d == '0) || (c == d - 1'b1);
  endfunction

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req[i] && (req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
  end

  apbspi_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .grant (win)
  );

  always_comb begin
    win_idx = '0;
    win_len = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) begin
        win_idx = PTR_W'(i);
        win_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign start_grant = (state == ST_IDLE) && spi_enable && (|eligible);
  assign abort       = !spi_enable &&
                       (state inside {ST_SETUP, ST_XFER, ST_WAIT, ST_HOLD});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_grant) state_nxt = ST_SETUP;
        ST_SETUP: if (dly_done(cnt, cs_setup)) state_nxt = ST_XFER;
        ST_XFER:  if (!spi_busy) state_nxt = ST_WAIT;
        ST_WAIT:  if (spi_trx_done)
                    state_nxt = (remaining == LEN_WIDTH'(1)) ? ST_HOLD : ST_XFER;
        ST_HOLD:  if (dly_done(cnt, cs_hold)) state_nxt = ST_GAP;
        ST_GAP:   if (dly_done(cnt, cs_gap)) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    spi_start_nxt   = 1'b0;
    word_done_nxt   = 1'b0;
    burst_abort_nxt = 1'b0;
    burst_done_nxt  = '0;
    cs_n_nxt        = cs_n;
    grant_nxt       = grant;
    remaining_nxt   = remaining;
    ptr_nxt         = ptr;
    cnt_nxt         = (state_nxt != state) ? '0 : cnt + 1'b1;
    if (abort) begin
      cs_n_nxt        = '1;
      grant_nxt       = '0;
      burst_abort_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start_grant) begin
          grant_nxt     = win;
          cs_n_nxt      = ~win;
          remaining_nxt = win_len;
          ptr_nxt       = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
        ST_XFER: spi_start_nxt = !spi_busy;
        ST_WAIT: if (spi_trx_done) begin
          word_done_nxt = 1'b1;
          remaining_nxt = remaining - 1'b1;
        end
        ST_HOLD: if (dly_done(cnt, cs_hold)) begin
          cs_n_nxt       = '1;
          grant_nxt      = '0;
          burst_done_nxt = grant;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ptr         <= '0;
      cnt         <= '0;
      remaining   <= '0;
      spi_start   <= 1'b0;
      word_done   <= 1'b0;
      burst_abort <= 1'b0;
      burst_done  <= '0;
      cs_n        <= '1;
      grant       <= '0;
    end else begin
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      remaining   <= remaining_nxt;
      spi_start   <= spi_start_nxt;
      word_done   <= word_done_nxt;
      burst_abort <= burst_abort_nxt;
      burst_done  <= burst_done_nxt;
      cs_n        <= cs_n_nxt;
      grant       <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_apbspi_xfer_sched.sv
// Scoreboard bench for apbspi_xfer_sched: expected grants and burst
// completions are queued as stimulus is applied and retired by a monitor.
module tb_apbspi_xfer_sched;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int DW = 8;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [DW-1:0] cs_setup = '0, cs_hold = '0, cs_gap = '0;
  logic          spi_enable = 1'b1, spi_busy = 1'b0, spi_trx_done = 1'b0;
  logic          spi_start, word_done, burst_abort;
  logic [N-1:0]  cs_n, grant, burst_done;

  apbspi_xfer_sched #(.N_REQ(N), .LEN_WIDTH(LW), .DLY_WIDTH(DW)) dut (
    .pclk         (pclk),
    .preset       (preset),
    .req          (req),
    .req_len      (req_len),
    .cs_setup     (cs_setup),
    .cs_hold      (cs_hold),
    .cs_gap       (cs_gap),
    .spi_enable   (spi_enable),
    .spi_busy     (spi_busy),
    .spi_trx_done (spi_trx_done),
    .spi_start    (spi_start),
    .cs_n         (cs_n),
    .grant        (grant),
    .word_done    (word_done),
    .burst_done   (burst_done),
    .burst_abort  (burst_abort)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0, n_fail = 0;
  logic [N-1:0] exp_grant_q[$];
  logic [N-1:0] exp_done_q[$];
  int cyc = 0, n_start = 0, n_wd = 0, n_bd = 0, n_abort = 0;
  int g_cyc = 0, s_cyc = 0, wd_cyc = 0, csr_cyc = 0;
  int eng_lat = 1;
  logic [N-1:0] prev_grant = '0, prev_cs = '1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_len(input int i, input logic [LW-1:0] v);
    req_len[i*LW +: LW] = v;
  endtask

  task automatic clear_counts();
    n_start = 0; n_wd = 0; n_bd = 0; n_abort = 0;
  endtask

  task automatic wait_grants(input string tag);
    int t = 0;
    while (exp_grant_q.size() != 0 && t < 300) begin
      @(negedge pclk);
      t++;
    end
    check(tag, exp_grant_q.size(), 0);
  endtask

  task automatic wait_dones(input string tag);
    int t = 0;
    while (exp_done_q.size() != 0 && t < 300) begin
      @(negedge pclk);
      t++;
    end
    check(tag, exp_done_q.size(), 0);
  endtask

  // SPI engine model: answers each start with a done pulse eng_lat cycles later.
  initial forever begin
    @(negedge pclk);
    spi_trx_done = 1'b0;
    if (spi_start === 1'b1) begin
      repeat (eng_lat) @(negedge pclk);
      spi_trx_done = 1'b1;
    end
  end

  // Monitor: invariants every cycle, grants and completions against the queues.
  initial forever begin
    logic [N-1:0] inv_cs;
    @(negedge pclk);
    cyc++;
    inv_cs = ~cs_n;
    check("grant_eq_not_cs", grant, inv_cs);
    check("grant_onehot0", $onehot0(grant), 1);
    if (grant != '0 && prev_grant == '0) begin
      g_cyc = cyc;
      if (exp_grant_q.size() == 0) check("grant_unexpected", grant, 0);
      else check("grant_order", grant, exp_grant_q.pop_front());
    end
    if (burst_done != '0) begin
      n_bd++;
      if (exp_done_q.size() == 0) check("done_unexpected", burst_done, 0);
      else check("done_owner", burst_done, exp_done_q.pop_front());
    end
    if (spi_start === 1'b1) begin
      if (n_start == 0) s_cyc = cyc;
      n_start++;
    end
    if (word_done === 1'b1) begin
      n_wd++;
      wd_cyc = cyc;
    end
    if (burst_abort === 1'b1) n_abort++;
    if (cs_n == '1 && prev_cs != '1) csr_cyc = cyc;
    prev_grant = grant;
    prev_cs    = cs_n;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge pclk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_grant", grant, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_word_done", word_done, 0);
    check("rst_burst_done", burst_done, 0);
    check("rst_burst_abort", burst_abort, 0);
    cs_setup = 8'd2; cs_hold = 8'd1; cs_gap = 8'd2;
    preset = 1'b0;

    // Single burst on requester 1
    @(negedge pclk);
    clear_counts();
    set_len(1, 8'd3);
    req = 4'b0010;
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    wait_grants("t1_grant_tmo");
    check("t1_cs_n", cs_n, 4'b1101);
    req = '0;
    wait_dones("t1_done_tmo");
    check("t1_setup_to_start", s_cyc - g_cyc, 3);
    check("t1_hold_to_cs_high", csr_cyc - wd_cyc, 1);
    check("t1_n_start", n_start, 3);
    check("t1_n_word_done", n_wd, 3);
    check("t1_n_burst_done", n_bd, 1);

    // Fairness after a fresh reset: 0,1,2,3,0
    repeat (4) @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    clear_counts();
    cs_setup = '0; cs_hold = '0; cs_gap = '0;
    for (int i = 0; i < N; i++) set_len(i, 8'd1);
    foreach (exp_grant_q[i]) exp_grant_q.delete(i);
    for (int k = 0; k < 5; k++) begin
      exp_grant_q.push_back(4'b0001 << (k % N));
      exp_done_q.push_back(4'b0001 << (k % N));
    end
    req = 4'b1111;
    wait_grants("t2_grant_tmo");
    req = '0;
    wait_dones("t2_done_tmo");
    repeat (10) @(negedge pclk);
    check("t2_n_burst_done", n_bd, 5);
    check("t2_n_word_done", n_wd, 5);

    // Zero-length request is never granted
    clear_counts();
    set_len(2, 8'd0);
    set_len(3, 8'd2);
    exp_grant_q.push_back(4'b1000);
    exp_done_q.push_back(4'b1000);
    req = 4'b1100;
    wait_grants("t3_grant_tmo");
    req = 4'b0100;
    wait_dones("t3_done_tmo");
    repeat (20) @(negedge pclk);
    req = '0;
    check("t3_n_word_done", n_wd, 2);
    check("t3_n_burst_done", n_bd, 1);

    // Abort during WAIT of word 2 of 4
    clear_counts();
    eng_lat = 3;
    set_len(0, 8'd4);
    exp_grant_q.push_back(4'b0001);
    req = 4'b0001;
    wait_grants("t4_grant_tmo");
    req = '0;
    begin
      int t = 0;
      while (n_start < 2 && t < 300) begin
        @(negedge pclk);
        t++;
      end
    end
    check("t4_second_start", n_start, 2);
    spi_enable = 1'b0;
    @(negedge pclk);
    check("t4_abort_pulse", burst_abort, 1);
    check("t4_abort_cs_n", cs_n, 4'hF);
    check("t4_abort_grant", grant, 0);
    check("t4_abort_start", spi_start, 0);
    repeat (10) @(negedge pclk);
    check("t4_n_abort", n_abort, 1);
    check("t4_no_burst_done", n_bd, 0);
    check("t4_late_done_ignored", n_wd, 1);
    check("t4_n_start", n_start, 2);
    spi_enable = 1'b1;
    eng_lat = 1;
    repeat (4) @(negedge pclk);

    // Busy stall in XFER
    clear_counts();
    spi_busy = 1'b1;
    set_len(2, 8'd1);
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0100);
    req = 4'b0100;
    wait_grants("t5_grant_tmo");
    req = '0;
    repeat (6) @(negedge pclk);
    check("t5_start_withheld", n_start, 0);
    spi_busy = 1'b0;
    wait_dones("t5_done_tmo");
    check("t5_n_start", n_start, 1);
    check("t5_n_word_done", n_wd, 1);
    repeat (6) @(negedge pclk);

    // Reset in XFER, then requester 0 wins first
    clear_counts();
    spi_busy = 1'b1;
    set_len(2, 8'd2);
    exp_grant_q.push_back(4'b0100);
    req = 4'b0100;
    wait_grants("t6_grant_tmo");
    repeat (2) @(negedge pclk);
    #2 preset = 1'b1;
    #1;
    check("t6_async_cs_n", cs_n, 4'hF);
    check("t6_async_grant", grant, 0);
    spi_busy = 1'b0;
    set_len(0, 8'd1);
    set_len(2, 8'd1);
    req = 4'b0101;
    exp_grant_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0100);
    exp_done_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0100);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("t6_first_grant", grant, 4'b0001);
    wait_grants("t6_grant2_tmo");
    req = '0;
    wait_dones("t6_done_tmo");
    repeat (10) @(negedge pclk);
    check("t6_n_burst_done", n_bd, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apbspi_xfer_sched.md
APBSPI_XFER_SCHED -- requirements
Module: apbspi_xfer_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing the SPI engine.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the per-requester burst word count.
REQ-003 SHALL have parameter DLY_WIDTH, default 8, meaning width of the chip-select timing counters.
REQ-004 SHALL have ports: pclk  input  1  clock; preset  input  1  reset (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have ports: req  input  N_REQ  burst request per requester; req_len  input  N_REQ*LEN_WIDTH  words per burst, requester i at slice i.
REQ-006 SHALL have ports: cs_setup, cs_hold, cs_gap  input  DLY_WIDTH each  CS-to-first-start, last-done-to-CS-release and inter-burst idle cycles.
REQ-007 SHALL have ports: spi_enable  input  1; spi_busy  input  1; spi_trx_done  input  1  one-cycle word-complete pulse from the SPI engine.
REQ-008 SHALL have ports: spi_start  output  1  one-cycle word start; cs_n  output  N_REQ  active-low chip selects; grant  output  N_REQ  one-hot owner.
REQ-009 SHALL have ports: word_done  output  1; burst_done  output  N_REQ  one-cycle per-requester completion; burst_abort  output  1  one-cycle abort pulse.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, XFER, WAIT, HOLD, GAP; all outputs registered.
REQ-011 IDLE: eligible = req[i] and req_len slice non-zero; if spi_enable and any eligible, next cycle grant = round-robin winner, cs_n[winner]=0, length latched, -> SETUP.
REQ-012 Round-robin: search starts at index after last granted (wraps N_REQ-1 -> 0); pointer resets to 0, so requester 0 wins a first simultaneous request.
REQ-013 Zero-length requests SHALL never be granted; req changes after grant SHALL be ignored until burst end.
REQ-014 SETUP: stays cs_setup cycles (0 = one-cycle pass-through), then -> XFER.
REQ-015 XFER: spi_start=1 for exactly one cycle only if spi_busy=0, else wait in XFER; -> WAIT.
REQ-016 WAIT: on spi_trx_done, word_done=1 next cycle, remaining count decrements; remaining>0 -> XFER, else -> HOLD.
REQ-017 HOLD: stays cs_hold cycles (0 = one cycle), then cs_n all 1, burst_done[owner]=1 for one cycle, grant=0, -> GAP.
REQ-018 GAP: stays cs_gap cycles (0 = one cycle), then -> IDLE; no grant issued during GAP.
REQ-019 spi_enable low in SETUP/XFER/WAIT/HOLD SHALL abort: next cycle cs_n all 1, grant=0, spi_start=0, burst_abort=1, no burst_done, pointer advances, -> IDLE.
REQ-020 spi_trx_done outside WAIT SHALL be ignored; back-to-back words SHALL need no idle cycle beyond XFER/WAIT.
REQ-021 At most one cs_n bit low at any time; grant SHALL equal ~cs_n while owned.

Reset
REQ-022 preset SHALL asynchronously force IDLE, cs_n all 1, grant 0, spi_start 0, word_done 0, burst_done 0, burst_abort 0, counters 0, RR pointer 0, including mid-burst.
REQ-023 First grant SHALL be possible on the first pclk edge after preset deasserts.

Structure
REQ-024 State enum and default parameter constants SHALL live in shared package apbspi_sched_pkg.
REQ-025 Round-robin selection SHALL be a sub-module apbspi_rr_arbiter (req, pointer in; one-hot grant out; combinational).

Verification
REQ-026 Single burst: req[1]=1, len=3, setup=2, hold=1, gap=2 -> cs_n=4'b1101, three spi_start pulses, three word_done, burst_done[1] once, cs high 1 hold cycle after third done.
REQ-027 Fairness: req=4'b1111 constant, len=1 each -> grant order 0,1,2,3,0; no requester granted twice before others.
REQ-028 Zero length: req[2]=1 len=0 with req[3]=1 len=2 -> only requester 3 granted; requester 2 never.
REQ-029 Abort: spi_enable drop in WAIT of word 2 of 4 -> next cycle cs_n=all 1, burst_abort=1, no burst_done, then IDLE.
REQ-030 Busy stall: spi_busy=1 for 5 cycles in XFER -> spi_start withheld, then single pulse when busy clears.
REQ-031 Reset mid-burst: preset asserted in XFER -> cs_n all 1 same cycle, next grant after release goes to requester 0.
